// File: rtl/spi_master_ctrl.sv
// SPI master for the slave-plus-memory interface: serializes one host command per ss_n frame
// and, for read-data frames, collects the returned byte from MISO.
module spi_master_ctrl #(
  parameter int unsigned READ_GAP = 2,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              ss_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int unsigned TxW = DATA_W + 2;
  localparam logic [3:0] ShiftLoad = 4'(TxW - 1);
  localparam logic [3:0] RecvLoad  = 4'(DATA_W - 1);
  localparam logic [3:0] GapLoad   = 4'((READ_GAP == 0) ? 0 : READ_GAP - 1);

  typedef enum logic [2:0] {StIdle, StSel, StShift, StGap, StRecv, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [TxW-1:0]    tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rd_q, rd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rsp_data_q <= '0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rsp_data_q <= rsp_data_d;
      rd_q       <= rd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rsp_data_d = rsp_data_q;
    rd_d       = rd_q;
    ss_n       = 1'b1;
    MOSI       = 1'b0;
    rsp_valid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          tx_d    = {cmd, cmd_data};
          rd_d    = (cmd == 2'b11);
          state_d = StSel;
        end
      end
      // SEL already shows the first frame bit, so SHIFT repeats it without shifting first.
      StSel: begin
        ss_n    = 1'b0;
        MOSI    = tx_q[TxW-1];
        cnt_d   = ShiftLoad;
        state_d = StShift;
      end
      StShift: begin
        ss_n = 1'b0;
        MOSI = tx_q[TxW-1];
        tx_d = {tx_q[TxW-2:0], 1'b0};
        if (cnt_q == 4'd0) begin
          if (!rd_q) begin
            state_d = StDone;
          end else if (READ_GAP == 0) begin
            cnt_d   = RecvLoad;
            state_d = StRecv;
          end else begin
            cnt_d   = GapLoad;
            state_d = StGap;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StGap: begin
        ss_n = 1'b0;
        if (cnt_q == 4'd0) begin
          cnt_d   = RecvLoad;
          state_d = StRecv;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRecv: begin
        ss_n = 1'b0;
        rx_d = {rx_q[DATA_W-2:0], MISO};
        if (cnt_q == 4'd0) begin
          rsp_data_d = {rx_q[DATA_W-2:0], MISO};
          state_d    = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        rsp_valid = rd_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign cmd_ready = ~busy;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (read gap 3 and 0) driven by a behavioural
// slave/memory model; table-driven frames plus reset and back-to-back sequences.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cmd;
  logic [7:0] cmd_data;
  logic [1:0] cmd_valid_w, cmd_ready_w, busy_w, rsp_valid_w, ss_n_w, mosi_w, miso_w;
  logic [7:0] rsp_data_w [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.READ_GAP(3), .DATA_W(8)) u_dut_g3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_w[0]), .cmd_ready(cmd_ready_w[0]),
    .cmd(cmd), .cmd_data(cmd_data), .rsp_valid(rsp_valid_w[0]), .rsp_data(rsp_data_w[0]),
    .busy(busy_w[0]), .ss_n(ss_n_w[0]), .MOSI(mosi_w[0]), .MISO(miso_w[0])
  );

  spi_master_ctrl #(.READ_GAP(0), .DATA_W(8)) u_dut_g0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_w[1]), .cmd_ready(cmd_ready_w[1]),
    .cmd(cmd), .cmd_data(cmd_data), .rsp_valid(rsp_valid_w[1]), .rsp_data(rsp_data_w[1]),
    .busy(busy_w[1]), .ss_n(ss_n_w[1]), .MOSI(mosi_w[1]), .MISO(miso_w[1])
  );

  // Slave model state, one entry per instance (index 0: gap 3, index 1: gap 0).
  int         s_pos [2], s_hi [2], s_len [2], s_gap [2], s_frames [2], s_rsp [2], s_tail [2];
  int         s_done_ok [2];
  logic [10:0] s_bits [2], s_last [2], s_prev [2];
  logic [7:0]  s_addr [2];
  logic [7:0]  s_mem [2][256];

  always @(negedge clk) begin
    int g;
    int p;
    for (int i = 0; i < 2; i++) begin
      g = (i == 0) ? 3 : 0;
      if (!rst_n) begin
        s_pos[i]  = 0;
        s_hi[i]   = 0;
        miso_w[i] = 1'b1;
      end else begin
        if (rsp_valid_w[i]) s_rsp[i]++;
        if (!ss_n_w[i]) begin
          if (s_pos[i] == 0) s_gap[i] = s_hi[i];
          p = s_pos[i];
          if (p < 11) s_bits[i] = {s_bits[i][9:0], mosi_w[i]};
          else if (mosi_w[i]) s_tail[i]++;
          s_pos[i]++;
          // Drive the read byte only inside the expected receive window; 1s elsewhere.
          if (p >= 11 + g && p <= 18 + g && s_bits[i][9:8] == 2'b11)
            miso_w[i] = s_mem[i][s_addr[i]][7-(p-11-g)];
          else
            miso_w[i] = 1'b1;
        end else begin
          miso_w[i] = 1'b1;
          if (s_pos[i] > 0) begin
            s_len[i]     = s_pos[i];
            s_prev[i]    = s_last[i];
            s_last[i]    = s_bits[i];
            s_frames[i]++;
            s_done_ok[i] = (busy_w[i] && !cmd_ready_w[i]) ? 1 : 0;
            case (s_bits[i][9:8])
              2'b00, 2'b10: s_addr[i] = s_bits[i][7:0];
              2'b01:        s_mem[i][s_addr[i]] = s_bits[i][7:0];
              default: ;
            endcase
            s_pos[i] = 0;
            s_hi[i]  = 1;
          end else begin
            s_hi[i]++;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int i, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready_w[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < 100) ? 1 : 0, 1);
  endtask

  task automatic run_cmd(input int i, input logic [1:0] c, input logic [7:0] d);
    int n;
    @(negedge clk);
    cmd            = c;
    cmd_data       = d;
    cmd_valid_w[i] = 1'b1;
    n = 0;
    while (!cmd_ready_w[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    cmd_valid_w[i] = 1'b0;
    cmd            = ~c;
    cmd_data       = ~d;
    wait_ready(i, "frame_timeout");
  endtask

  typedef struct {
    int          inst;
    logic [1:0]  c;
    logic [7:0]  d;
    int          len;
    logic [10:0] bits;
    int          rsp_inc;
    logic [7:0]  rsp;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int r0, f0, t0, t1, tl0, acc, n;

    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int r0, f0, tl0, t0, t1, acc, n;

    // {inst, cmd, data, ss_n-low cycles, SEL+SHIFT MOSI bits, rsp pulses, rsp_data after}
    vecs[0]  = '{0, 2'b00, 8'h5A, 11, 11'b000_0101_1010, 0, 8'h00};
    vecs[1]  = '{0, 2'b00, 8'h10, 11, 11'b000_0001_0000, 0, 8'h00};
    vecs[2]  = '{0, 2'b01, 8'hC3, 11, 11'b001_1100_0011, 0, 8'h00};
    vecs[3]  = '{0, 2'b10, 8'h10, 11, 11'b110_0001_0000, 0, 8'h00};
    vecs[4]  = '{0, 2'b11, 8'h00, 22, 11'b111_0000_0000, 1, 8'hC3};
    vecs[5]  = '{1, 2'b00, 8'h20, 11, 11'b000_0010_0000, 0, 8'h00};
    vecs[6]  = '{1, 2'b01, 8'hA5, 11, 11'b001_1010_0101, 0, 8'h00};
    vecs[7]  = '{1, 2'b10, 8'h20, 11, 11'b110_0010_0000, 0, 8'h00};
    vecs[8]  = '{1, 2'b11, 8'h3C, 19, 11'b111_0011_1100, 1, 8'hA5};
    vecs[9]  = '{0, 2'b00, 8'h20, 11, 11'b000_0010_0000, 0, 8'hC3};
    vecs[10] = '{0, 2'b01, 8'hA5, 11, 11'b001_1010_0101, 0, 8'hC3};
    vecs[11] = '{0, 2'b10, 8'h20, 11, 11'b110_0010_0000, 0, 8'hC3};
    vecs[12] = '{0, 2'b11, 8'hFF, 22, 11'b111_1111_1111, 1, 8'hA5};

    rst_n       = 1'b0;
    cmd_valid_w = 2'b00;
    cmd         = 2'b00;
    cmd_data    = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: {ss_n, MOSI, cmd_ready, busy, rsp_valid, rsp_data}.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        check($sformatf("idle_c%0d_i%0d", c, i),
              {ss_n_w[i], mosi_w[i], cmd_ready_w[i], busy_w[i], rsp_valid_w[i], rsp_data_w[i]},
              {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    end

    foreach (vecs[k]) begin
      r0  = s_rsp[vecs[k].inst];
      f0  = s_frames[vecs[k].inst];
      tl0 = s_tail[vecs[k].inst];
      run_cmd(vecs[k].inst, vecs[k].c, vecs[k].d);
      check($sformatf("v%0d_frames", k), s_frames[vecs[k].inst] - f0, 1);
      check($sformatf("v%0d_ssn_low", k), s_len[vecs[k].inst], vecs[k].len);
      check($sformatf("v%0d_mosi_bits", k), s_last[vecs[k].inst], vecs[k].bits);
      check($sformatf("v%0d_mosi_tail", k), s_tail[vecs[k].inst] - tl0, 0);
      check($sformatf("v%0d_done_busy", k), s_done_ok[vecs[k].inst], 1);
      check($sformatf("v%0d_rsp_pulses", k), s_rsp[vecs[k].inst] - r0, vecs[k].rsp_inc);
      check($sformatf("v%0d_rsp_data", k), rsp_data_w[vecs[k].inst], vecs[k].rsp);
    end

    // Reset during the 5th SHIFT cycle of an RD_DATA frame.
    r0 = s_rsp[0];
    @(negedge clk);
    cmd            = 2'b11;
    cmd_data       = 8'h00;
    cmd_valid_w[0] = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_w[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_pre_ssn", ss_n_w[0], 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs",
          {ss_n_w[0], mosi_w[0], cmd_ready_w[0], busy_w[0], rsp_valid_w[0], rsp_data_w[0]},
          {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_no_rsp", s_rsp[0] - r0, 0);
    check("rst_rsp_data", rsp_data_w[0], 8'h00);
    run_cmd(0, 2'b01, 8'hFF);
    check("post_rst_len", s_len[0], 11);
    check("post_rst_bits", s_last[0], 11'b001_1111_1111);
    check("post_rst_rsp_data", rsp_data_w[0], 8'h00);

    // cmd_valid held across a frame: second accept only in the IDLE after DONE.
    f0  = s_frames[0];
    acc = 0;
    n   = 0;
    t0  = 0;
    t1  = 0;
    @(negedge clk);
    cmd            = 2'b00;
    cmd_data       = 8'h11;
    cmd_valid_w[0] = 1'b1;
    while (acc < 2 && n < 100) begin
      if (cmd_ready_w[0]) begin
        acc++;
        if (acc == 1) t0 = n;
        else t1 = n;
      end
      @(posedge clk);
      #1;
      if (acc == 1) cmd_data = 8'h22;
      if (acc == 2) cmd_valid_w[0] = 1'b0;
      @(negedge clk);
      n++;
    end
    check("b2b_accepts", acc, 2);
    wait_ready(0, "b2b_timeout");
    repeat (20) @(negedge clk);
    check("b2b_period", t1 - t0, 13);
    check("b2b_frames", s_frames[0] - f0, 2);
    check("b2b_first_bits", s_prev[0], 11'b000_0001_0001);
    check("b2b_second_bits", s_last[0], 11'b000_0010_0010);
    check("b2b_ssn_gap", s_gap[0], 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
